bcd_stopwatch: RTL and testbench

- Downstream consumer of the BCD divide-by-10 counter. Takes its clk_div10_out as a tick and accumulates elapsed time in four BCD digits: M:ST.t, i.e. minutes, seconds-tens, seconds-units, tenths.
- Start/stop/clear control FSM; digits feed the display stage directly.

---
 rtl/bcd_stopwatch_pkg.sv | 14 +
 rtl/bcd_stopwatch_digit.sv | 41 ++++
 rtl/bcd_stopwatch.sv | 123 ++++++++++++
 tb/tb_bcd_stopwatch.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/bcd_stopwatch_pkg.sv
// Shared types and constants for the BCD stopwatch and its digit cells.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  localparam logic [3:0] BCD_MAX          = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX_DEF = 4'd5;
  localparam logic [3:0] MIN_MAX_DEF      = 4'd9;

endpackage

// File: rtl/bcd_stopwatch_digit.sv
// Single BCD digit cell: counts 0..MAX when enabled, wraps to 0 and raises
// carry_out combinationally so the next cell advances on the same edge.
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter logic [3:0] MAX = BCD_MAX
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  output logic [3:0] q,
  output logic       carry_out
);

  logic [3:0] q_q;
  logic [3:0] q_d;

  // Next value: clear dominates, then increment with wrap at MAX.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = 4'd0;
    end else if (en) begin
      q_d = (q_q >= MAX) ? 4'd0 : q_q + 4'd1;
    end
  end

  // Digit register, async active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= 4'd0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q         = q_q;
  assign carry_out = en && (q_q == MAX);

endmodule

// File: rtl/bcd_stopwatch.sv
// Stopwatch M:ST.t driven by the divide-by-10 tick. Holds the start/stop/clear
// FSM, the tick rising-edge detector and the wrap pulse register; the four
// digits are a carry chain of bcd_digit cells.
//
// state    | meaning
// ---------+----------------------------------------------
// ST_IDLE  | cleared, digits 0, waiting for start
// ST_RUN   | counting tick rising edges
// ST_PAUSE | digits held, start resumes, clear zeroes
module bcd_stopwatch
  import stopwatch_pkg::*;
#(
  parameter logic [3:0] SEC_TENS_MAX = SEC_TENS_MAX_DEF,
  parameter logic [3:0] MIN_MAX      = MIN_MAX_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic       running,
  output logic       wrap_pulse
);

  state_e state_q;
  logic   running_q;
  logic   tick_q;
  logic   wrap_pulse_q;

  logic   tick_rise;
  logic   inc;
  logic   carry0, carry1, carry2, carry3;

  assign tick_rise = tick_in & ~tick_q;
  // Clear wins over a coincident tick so the digits land on zero.
  assign inc       = (state_q == ST_RUN) && tick_rise && !clear;

  // Tick history for the rising-edge detector.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= tick_in;
    end
  end

  // Control FSM with registered running flag; priority clear > stop > start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      running_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!clear && start) begin
            state_q   <= ST_RUN;
            running_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (clear) begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
          end else if (stop) begin
            state_q   <= ST_PAUSE;
            running_q <= 1'b0;
          end
        end
        ST_PAUSE: begin
          if (clear) begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
          end else if (start) begin
            state_q   <= ST_RUN;
            running_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  // Wrap pulse: the full chain rolled over on this edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrap_pulse_q <= 1'b0;
    end else begin
      wrap_pulse_q <= carry3;
    end
  end

  bcd_digit #(.MAX(BCD_MAX)) u_tenths (
    .clk(clk), .rst(rst), .en(inc), .clr(clear),
    .q(digit0), .carry_out(carry0)
  );

  bcd_digit #(.MAX(BCD_MAX)) u_sec_units (
    .clk(clk), .rst(rst), .en(carry0), .clr(clear),
    .q(digit1), .carry_out(carry1)
  );

  bcd_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
    .clk(clk), .rst(rst), .en(carry1), .clr(clear),
    .q(digit2), .carry_out(carry2)
  );

  bcd_digit #(.MAX(MIN_MAX)) u_minutes (
    .clk(clk), .rst(rst), .en(carry2), .clr(clear),
    .q(digit3), .carry_out(carry3)
  );

  assign running    = running_q;
  assign wrap_pulse = wrap_pulse_q;

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Directed bench for bcd_stopwatch: reset, counting, carry/wrap, pause,
// edge rules and async reset mid-run.
module tb_bcd_stopwatch;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick_in = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] digit0, digit1, digit2, digit3;
  logic       running, wrap_pulse;

  int errors = 0;
  int checks = 0;

  bcd_stopwatch dut (
    .clk(clk), .rst(rst), .tick_in(tick_in),
    .start(start), .stop(stop), .clear(clear),
    .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
    .running(running), .wrap_pulse(wrap_pulse)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle 1 ns past the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // n rising edges on tick_in, each high for hi cycles then low for lo cycles.
  task automatic pulses(input int n, input int hi, input int lo);
    for (int i = 0; i < n; i++) begin
      tick_in = 1'b1;
      repeat (hi) step();
      tick_in = 1'b0;
      repeat (lo) step();
    end
  endtask

  function automatic logic [15:0] digits();
    return {digit3, digit2, digit1, digit0};
  endfunction

  initial begin
    // Reset held with active inputs
    rst = 1'b0; start = 1'b1; tick_in = 1'b1;
    repeat (3) step();
    check("reset_digits", digits(), 16'h0000);
    check("reset_running", {15'd0, running}, 16'd0);
    check("reset_wrap", {15'd0, wrap_pulse}, 16'd0);
    start = 1'b0; tick_in = 1'b0;
    rst = 1'b1;
    repeat (2) step();
    check("post_reset_idle", {15'd0, running}, 16'd0);

    // Basic count
    start = 1'b1; step(); start = 1'b0;
    check("start_running", {15'd0, running}, 16'd1);
    pulses(10, 5, 5);
    check("basic_count", digits(), 16'h0010);
    check("basic_running", {15'd0, running}, 16'd1);

    // Carry and wrap
    clear = 1'b1; step(); clear = 1'b0;
    check("clear_digits", digits(), 16'h0000);
    check("clear_running", {15'd0, running}, 16'd0);
    start = 1'b1; step(); start = 1'b0;
    pulses(5999, 1, 1);
    check("max_count", digits(), 16'h9599);
    check("max_no_wrap", {15'd0, wrap_pulse}, 16'd0);
    tick_in = 1'b1; step();
    check("wrap_digits", digits(), 16'h0000);
    check("wrap_pulse_hi", {15'd0, wrap_pulse}, 16'd1);
    check("wrap_running", {15'd0, running}, 16'd1);
    tick_in = 1'b0; step();
    check("wrap_pulse_lo", {15'd0, wrap_pulse}, 16'd0);
    pulses(3, 1, 1);
    check("count_after_wrap", digits(), 16'h0003);

    // Pause and resume
    clear = 1'b1; step(); clear = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    pulses(25, 1, 1);
    check("pre_stop", digits(), 16'h0025);
    stop = 1'b1; step(); stop = 1'b0;
    check("stop_running", {15'd0, running}, 16'd0);
    pulses(20, 1, 1);
    check("paused_hold", digits(), 16'h0025);
    check("paused_running", {15'd0, running}, 16'd0);
    start = 1'b1; step(); start = 1'b0;
    check("resume_running", {15'd0, running}, 16'd1);
    pulses(5, 1, 1);
    check("resume_count", digits(), 16'h0030);

    // Held-high tick counts once
    tick_in = 1'b1;
    repeat (50) step();
    tick_in = 1'b0; step();
    check("held_high_once", digits(), 16'h0031);

    // Tick coinciding with stop: count applied, then pause
    tick_in = 1'b1; stop = 1'b1; step();
    tick_in = 1'b0; stop = 1'b0;
    check("tick_stop_count", digits(), 16'h0032);
    check("tick_stop_state", {15'd0, running}, 16'd0);
    step();

    // Tick coinciding with clear: zeroed, idle
    start = 1'b1; step(); start = 1'b0;
    tick_in = 1'b1; clear = 1'b1; step();
    tick_in = 1'b0; clear = 1'b0;
    check("tick_clear_digits", digits(), 16'h0000);
    check("tick_clear_state", {15'd0, running}, 16'd0);
    pulses(2, 1, 1);
    check("idle_no_count", digits(), 16'h0000);

    // Async reset mid-run at 1:23.4
    start = 1'b1; step(); start = 1'b0;
    pulses(834, 1, 1);
    check("pre_reset_count", digits(), 16'h1234);
    #2 rst = 1'b0;
    #1;
    check("async_reset_digits", digits(), 16'h0000);
    check("async_reset_running", {15'd0, running}, 16'd0);
    step();
    rst = 1'b1;
    step();
    pulses(3, 1, 1);
    check("no_count_after_reset", digits(), 16'h0000);
    check("idle_after_reset", {15'd0, running}, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
